// File: rtl/vec_vrf_pkg.sv
// Shared types and helpers for the parametrised vector register file.
package vec_vrf_pkg;

   typedef enum logic {INIT, READY} state_t;

   localparam int VLEN_DEFAULT = 512;
   localparam int VLEN_BYTES   = VLEN_DEFAULT / 8;

   // Called in ascending port order, so the last (highest-index) hit wins the lane.
   function automatic logic [7:0] byte_pick(input logic [7:0] cur, input logic [7:0] wbyte,
                                            input logic hit);
      return hit ? wbyte : cur;
   endfunction

endpackage

// File: rtl/vec_vrf_byte_merge.sv
// Per-read-port write-before-read merge; only compiled with VEC_VRF_BYPASS_EN.
`ifdef VEC_VRF_BYPASS_EN
module vec_vrf_byte_merge
   import vec_vrf_pkg::*;
#(
   parameter int WPORT = 4,
   parameter int VLEN  = VLEN_DEFAULT,
   parameter int AW    = 5
) (
   input  logic [VLEN-1:0]                  arr_word,
   input  logic [AW-1:0]                    rd_addr,
   input  logic [WPORT-1:0]                 wr_en,
   input  logic [WPORT-1:0][VLEN/8-1:0]     wr_be,
   input  logic [WPORT-1:0][AW-1:0]         wr_addr,
   input  logic [WPORT-1:0][VLEN-1:0]       wr_data,
   output logic [VLEN-1:0]                  merged
);

   always_comb begin
      merged = arr_word;
      for (int i = 0; i < WPORT; i++) begin
         for (int b = 0; b < VLEN/8; b++) begin
            merged[b*8 +: 8] = byte_pick(merged[b*8 +: 8], wr_data[i][b*8 +: 8],
                                         wr_en[i] && wr_be[i][b] && (wr_addr[i] == rd_addr));
         end
      end
   end

endmodule
`endif

// File: rtl/vec_vrf_bank.sv
// Parametrised vector register file with sequential init/clear engine.
// VEC_VRF_BYPASS_EN selects write-before-read on same-cycle hits; default is read-before-write.
module vec_vrf_bank
   import vec_vrf_pkg::*;
#(
   parameter  int NREG  = 32,
   parameter  int WPORT = 4,
   parameter  int RPORT = 4,
   parameter  int VLEN  = VLEN_DEFAULT,
   localparam int AW    = $clog2(NREG)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              clk_en,
   input  logic                              clr_req,
   output logic                              busy,
   input  logic [WPORT-1:0]                  wr_en,
   input  logic [WPORT-1:0][VLEN/8-1:0]      wr_be,
   input  logic [WPORT-1:0][AW-1:0]          wr_addr,
   input  logic [WPORT-1:0][VLEN-1:0]        wr_data,
   input  logic [RPORT-1:0]                  rd_en,
   input  logic [RPORT-1:0][AW-1:0]          rd_addr,
   output logic [RPORT-1:0]                  rd_valid,
   output logic [RPORT-1:0][VLEN-1:0]        rd_data
);

   localparam int NB = VLEN / 8;

   state_t                       state_q, state_d;
   logic [AW-1:0]                cnt_q, cnt_d;
   logic                         busy_q, busy_d;
   logic [VLEN-1:0]              mem_q [NREG];
   logic [VLEN-1:0]              mem_d [NREG];
   logic [RPORT-1:0]             rd_valid_q, rd_valid_d;
   logic [RPORT-1:0][VLEN-1:0]   rd_data_q, rd_data_d;
   logic [RPORT-1:0][VLEN-1:0]   arr_word, rd_word;
   logic [RPORT-1:0]             rd_inrange;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      case (state_q)
         INIT: begin
            if (cnt_q == AW'(NREG - 1)) begin
               state_d = READY;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         READY: begin
            if (clr_req) begin
               state_d = INIT;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = INIT;
            cnt_d   = '0;
            busy_d  = 1'b1;
         end
      endcase
   end

   // Out-of-range writes are dropped; port order gives the highest index priority.
   always_comb begin
      mem_d = mem_q;
      if (state_q == INIT) begin
         mem_d[cnt_q] = '0;
      end else begin
         for (int i = 0; i < WPORT; i++) begin
            if (wr_en[i] && (int'(wr_addr[i]) < NREG)) begin
               for (int b = 0; b < NB; b++) begin
                  mem_d[wr_addr[i]][b*8 +: 8] = byte_pick(mem_d[wr_addr[i]][b*8 +: 8],
                                                          wr_data[i][b*8 +: 8], wr_be[i][b]);
               end
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < RPORT; i++) begin
         rd_inrange[i] = int'(rd_addr[i]) < NREG;
         arr_word[i]   = rd_inrange[i] ? mem_q[rd_addr[i]] : '0;
      end
   end

   for (genvar g = 0; g < RPORT; g++) begin : g_rd
`ifdef VEC_VRF_BYPASS_EN
      vec_vrf_byte_merge #(.WPORT(WPORT), .VLEN(VLEN), .AW(AW)) u_merge (
         .arr_word (arr_word[g]),
         .rd_addr  (rd_addr[g]),
         .wr_en    (wr_en),
         .wr_be    (wr_be),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .merged   (rd_word[g])
      );
`else
      assign rd_word[g] = arr_word[g];
`endif
   end

   always_comb begin
      rd_valid_d = '0;
      rd_data_d  = rd_data_q;
      if (state_q == READY) begin
         rd_valid_d = rd_en;
         for (int i = 0; i < RPORT; i++) begin
            if (rd_en[i]) rd_data_d[i] = rd_inrange[i] ? rd_word[i] : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         cnt_q      <= '0;
         busy_q     <= 1'b1;
         rd_valid_q <= '0;
         rd_data_q  <= '0;
      end else if (clk_en) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Storage is deliberately unreset; the init engine zeroes it.
   always_ff @(posedge clk) begin
      if (clk_en) mem_q <= mem_d;
   end

   assign busy     = busy_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_vec_vrf_bank.sv
// Scoreboard bench for vec_vrf_bank: default 32-entry instance plus an NREG=24 instance.
module tb_vec_vrf_bank;

   localparam int VL = 512;
   localparam int WP = 4;
   localparam int RP = 4;

   logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, clr_req = 1'b0;
   logic                    busy;
   logic [WP-1:0]           wr_en;
   logic [WP-1:0][63:0]     wr_be;
   logic [WP-1:0][4:0]      wr_addr;
   logic [WP-1:0][VL-1:0]   wr_data;
   logic [RP-1:0]           rd_en;
   logic [RP-1:0][4:0]      rd_addr;
   logic [RP-1:0]           rd_valid;
   logic [RP-1:0][VL-1:0]   rd_data;

   logic                    b_busy;
   logic [0:0]              b_wr_en, b_rd_en, b_rd_valid;
   logic [0:0][63:0]        b_wr_be;
   logic [0:0][4:0]         b_wr_addr, b_rd_addr;
   logic [0:0][VL-1:0]      b_wr_data, b_rd_data;

   vec_vrf_bank #(.NREG(32), .WPORT(WP), .RPORT(RP), .VLEN(VL)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .clr_req(clr_req), .busy(busy),
      .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
   );

   vec_vrf_bank #(.NREG(24), .WPORT(1), .RPORT(1), .VLEN(VL)) dut_b (
      .clk(clk), .rst_n(rst_n), .clk_en(1'b1), .clr_req(1'b0), .busy(b_busy),
      .wr_en(b_wr_en), .wr_be(b_wr_be), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_valid(b_rd_valid), .rd_data(b_rd_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int port; int cyc; logic [VL-1:0] d;} exp_t;
   exp_t sb[$];
   exp_t sb2[$];
   int n_vec = 0, n_err = 0;

   localparam logic [VL-1:0] ALL0 = '0;
   localparam logic [63:0]   BE_ALL = '1;

   function automatic logic [VL-1:0] rep(input logic [7:0] b);
      return {64{b}};
   endfunction

   task automatic chk(input string name, input logic [VL-1:0] act, input logic [VL-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitors: every valid read must match the oldest queued expectation, one cycle after issue.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         for (int i = 0; i < RP; i++) begin
            if (rd_valid[i]) begin
               if (sb.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexp_valid: port %0d got valid, want none", i);
               end else begin
                  e = sb.pop_front();
                  chk("rd_port", VL'(i), VL'(e.port));
                  chk("rd_latency", VL'(cyc), VL'(e.cyc + 1));
                  chk("rd_data", rd_data[i], e.d);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && b_rd_valid[0]) begin
         if (sb2.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexp_valid_b: got valid, want none");
         end else begin
            e = sb2.pop_front();
            chk("b_rd_latency", VL'(cyc), VL'(e.cyc + 1));
            chk("b_rd_data", b_rd_data[0], e.d);
         end
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic idle;
      wr_en = '0; rd_en = '0; clr_req = 1'b0; b_wr_en = '0; b_rd_en = '0;
   endtask

   task automatic rd(input int p, input int a, input logic [VL-1:0] e);
      rd_en[p] = 1'b1; rd_addr[p] = 5'(a);
      sb.push_back('{p, cyc, e});
   endtask

   task automatic wr(input int p, input int a, input logic [63:0] be, input logic [VL-1:0] d);
      wr_en[p] = 1'b1; wr_addr[p] = 5'(a); wr_be[p] = be; wr_data[p] = d;
   endtask

   task automatic b_rd(input int a, input logic [VL-1:0] e);
      b_rd_en = 1'b1; b_rd_addr[0] = 5'(a);
      sb2.push_back('{0, cyc, e});
   endtask

   task automatic wait_busy(input string name, input int exp_n);
      int n = 0;
      while (busy && n < 200) begin tick; n++; end
      chk(name, VL'(n), VL'(exp_n));
   endtask

   task automatic read_all_zero;
      for (int c = 0; c < 8; c++) begin
         for (int p = 0; p < RP; p++) rd(p, 4*c + p, ALL0);
         tick;
      end
      idle; tick;
   endtask

   initial begin
      int n;
      idle;
      wr_be = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      b_wr_be = '0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
      #12;
      chk("rst_busy", VL'(busy), VL'(1));
      chk("rst_rd_valid", VL'(rd_valid), '0);
      for (int p = 0; p < RP; p++) chk("rst_rd_data", rd_data[p], ALL0);
      @(posedge clk); #1 rst_n = 1'b1;
      wait_busy("init_cycles", 32);
      read_all_zero;

      // Single write then read on another port; data holds once rd_en drops.
      wr(0, 5, BE_ALL, rep(8'hAA)); tick; idle;
      rd(3, 5, rep(8'hAA)); tick; idle; tick;
      chk("rd_valid_drop", VL'(rd_valid[3]), VL'(0));
      chk("rd_data_hold", rd_data[3], rep(8'hAA));

      // Port 2 outranks port 1 on byte 0.
      wr(1, 7, BE_ALL, rep(8'h11)); wr(2, 7, 64'h1, rep(8'h22)); tick; idle;
      rd(0, 7, {{63{8'h11}}, 8'h22}); tick; idle;

      // Same-cycle write and read of a zeroed register.
      wr(0, 9, BE_ALL, rep(8'h33));
`ifdef VEC_VRF_BYPASS_EN
      rd(1, 9, rep(8'h33));
`else
      rd(1, 9, ALL0);
`endif
      tick; idle;
      rd(1, 9, rep(8'h33)); tick; idle; tick;

      // Reset mid-clear: immediate return to reset values, full re-init.
      clr_req = 1'b1; tick; clr_req = 1'b0;
      chk("clr_busy_rise", VL'(busy), VL'(1));
      for (int k = 0; k < 5; k++) tick;
      rst_n = 1'b0; #1;
      chk("midclr_rst_busy", VL'(busy), VL'(1));
      chk("midclr_rst_valid", VL'(rd_valid), '0);
      chk("midclr_rst_data1", rd_data[1], ALL0);
      chk("midclr_rst_data3", rd_data[3], ALL0);
      @(posedge clk); #1 rst_n = 1'b1;
      wait_busy("reinit_cycles", 32);

      // Fill, then clear with a 3-cycle clk_en stall and an ignored clr_req.
      wr(0, 1, BE_ALL, rep(8'hC1)); wr(1, 2, BE_ALL, rep(8'hC2));
      wr(2, 31, BE_ALL, rep(8'hC3)); wr(3, 0, BE_ALL, rep(8'hC4)); tick; idle;
      rd(0, 31, rep(8'hC3)); tick; idle; tick;
      clr_req = 1'b1; tick; clr_req = 1'b0;
      rd_en = '1; rd_addr = '{5'd1, 5'd2, 5'd31, 5'd0};
      n = 0;
      while (busy && n < 200) begin
         if (n == 10) clk_en = 1'b0;
         if (n == 13) clk_en = 1'b1;
         clr_req = (n == 20);
         tick; n++;
         chk("busy_rd_valid", VL'(rd_valid), '0);
      end
      idle; clk_en = 1'b1;
      chk("clear_cycles", VL'(n), VL'(35));
      read_all_zero;

      // NREG=24: out-of-range write dropped, out-of-range read gives 0 with valid.
      chk("b_busy_done", VL'(b_busy), VL'(0));
      b_wr_en = 1'b1; b_wr_addr[0] = 5'd30; b_wr_be[0] = BE_ALL; b_wr_data[0] = rep(8'h55);
      tick; idle;
      b_rd(30, ALL0); tick; b_rd(6, ALL0); tick; b_rd(14, ALL0); tick; idle;
      b_wr_en = 1'b1; b_wr_addr[0] = 5'd23; b_wr_data[0] = rep(8'h77); tick; idle;
      b_rd(23, rep(8'h77)); tick; idle;

      tick; tick; tick;
      chk("sb_drain", VL'(sb.size()), '0);
      chk("sb2_drain", VL'(sb2.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

endmodule
